// File: rtl/jet_pkg.sv
// rtl/jet_pkg.sv - shared jet word fields, trailer layout and sorter state encoding
package jet_pkg;
    localparam int JET_DW       = 32;
    localparam int JET_PT_MSB   = 31;
    localparam int JET_PT_LSB   = 20;
    localparam int JET_ETA_MSB  = 19;
    localparam int JET_ETA_LSB  = 15;
    localparam int JET_PHI_MSB  = 14;
    localparam int JET_PHI_LSB  = 10;
    localparam int JET_NTRK_MSB = 9;
    localparam int JET_NTRK_LSB = 5;

    localparam logic [JET_DW-1:0] EOE_MARKER = '0;

    localparam int TRL_EV_LSB   = 16;
    localparam int TRL_JCNT_LSB = 8;
    localparam int TRL_DCNT_LSB = 0;
    localparam int CNT_W        = 8;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_TRAILER = 2'd2
    } state_t;
endpackage

// File: rtl/jet_topn_sorter_if.sv
// rtl/jet_topn_sorter_if.sv - jet input stream and sorted output stream bundle
interface jet_topn_sorter_if #(
    parameter int DW = 32
);
    logic [DW-1:0] jet_in;
    logic          vld_in;
    logic          rdy_out;
    logic [DW-1:0] dout;
    logic          vld_out;
    logic          rdy_in;
    logic          last_out;

    modport slave  (input jet_in, vld_in, rdy_in, output rdy_out, dout, vld_out, last_out);
    modport master (output jet_in, vld_in, rdy_in, input rdy_out, dout, vld_out, last_out);
endinterface

// File: rtl/jet_sort_slot.sv
// rtl/jet_sort_slot.sv - one rank of the insertion sorter: stored jet plus pT comparator
module jet_sort_slot #(
    parameter int DW     = 32,
    parameter int PT_MSB = 31,
    parameter int PT_LSB = 20
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic          i_clr,
    input  logic [DW-1:0] i_cand,
    input  logic [DW-1:0] i_upper,
    input  logic          i_upper_vld,
    input  logic          i_ins,
    input  logic          i_shift,
    output logic          o_beats,
    output logic          o_vld,
    output logic [DW-1:0] o_jet
);
    logic          r_vld;
    logic [DW-1:0] r_jet;

    // Strict compare keeps the earlier of two equal-pT jets in the higher rank.
    assign o_beats = !r_vld || (i_cand[PT_MSB:PT_LSB] > r_jet[PT_MSB:PT_LSB]);
    assign o_vld   = r_vld;
    assign o_jet   = r_jet;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= 1'b0;
            r_jet <= '0;
        end else if (i_clr) begin
            r_vld <= 1'b0;
            r_jet <= '0;
        end else if (i_en) begin
            if (i_shift) begin
                r_vld <= i_upper_vld;
                r_jet <= i_upper;
            end else if (i_ins) begin
                r_vld <= 1'b1;
                r_jet <= i_cand;
            end
        end
    end
endmodule

// File: rtl/jet_topn_sorter.sv
// rtl/jet_topn_sorter.sv - keeps the NSLOT highest-pT jets per event and flushes them plus a trailer
module jet_topn_sorter
    import jet_pkg::*;
#(
    parameter int NSLOT  = 4,
    parameter int DW     = 32,
    parameter int PT_MSB = 31,
    parameter int PT_LSB = 20,
    parameter int EVW    = 12
) (
    input  logic              s_clk,
    input  logic              reset_n,
    jet_topn_sorter_if.slave  bus
);
    localparam int IW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

    state_t           r_state;
    logic [IW-1:0]    r_idx;
    logic             r_rdy;
    logic             r_vld;
    logic             r_last;
    logic [DW-1:0]    r_dout;
    logic [CNT_W-1:0] r_jet_cnt;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [EVW-1:0]   r_ev_num;

    logic [NSLOT-1:0] w_beats;
    logic [NSLOT-1:0] w_slot_vld;
    logic [NSLOT-1:0] w_ins;
    logic [NSLOT-1:0] w_shift;
    logic [DW-1:0]    w_slot_jet [NSLOT];
    logic [DW-1:0]    w_emit     [NSLOT];
    logic             w_jet_xfer;
    logic             w_mark_xfer;
    logic             w_out_xfer;
    logic             w_clr;
    logic [IW-1:0]    w_next_idx;
    logic [DW-1:0]    w_trailer;

    assign w_jet_xfer  = bus.vld_in && r_rdy && (bus.jet_in != EOE_MARKER);
    assign w_mark_xfer = bus.vld_in && r_rdy && (bus.jet_in == EOE_MARKER);
    assign w_out_xfer  = r_vld && bus.rdy_in;
    assign w_clr       = (r_state == ST_TRAILER) && w_out_xfer;
    assign w_next_idx  = r_idx + 1'b1;
    assign w_trailer   = {{(DW-EVW-2*CNT_W){1'b0}}, r_ev_num, r_jet_cnt, r_drop_cnt};

    // Slots are kept sorted, so the beat flags are monotone: the insert point is
    // the first set flag and every slot below it takes its upper neighbour.
    for (genvar k = 0; k < NSLOT; k++) begin : g_slot
        logic [DW-1:0] w_up;
        logic          w_up_vld;
        if (k == 0) begin : g_top
            assign w_shift[k] = 1'b0;
            assign w_up       = '0;
            assign w_up_vld   = 1'b0;
        end else begin : g_mid
            assign w_shift[k] = w_beats[k-1];
            assign w_up       = w_slot_jet[k-1];
            assign w_up_vld   = w_slot_vld[k-1];
        end
        assign w_ins[k]  = w_beats[k] && !w_shift[k];
        assign w_emit[k] = w_slot_vld[k] ? w_slot_jet[k] : '0;

        jet_sort_slot #(.DW(DW), .PT_MSB(PT_MSB), .PT_LSB(PT_LSB)) u_slot (
            .i_clk       (s_clk),
            .i_rst_n     (reset_n),
            .i_en        (w_jet_xfer),
            .i_clr       (w_clr),
            .i_cand      (bus.jet_in),
            .i_upper     (w_up),
            .i_upper_vld (w_up_vld),
            .i_ins       (w_ins[k]),
            .i_shift     (w_shift[k]),
            .o_beats     (w_beats[k]),
            .o_vld       (w_slot_vld[k]),
            .o_jet       (w_slot_jet[k])
        );
    end

    assign bus.rdy_out  = r_rdy;
    assign bus.dout     = r_dout;
    assign bus.vld_out  = r_vld;
    assign bus.last_out = r_last;

    always_ff @(posedge s_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_COLLECT;
            r_idx      <= '0;
            r_rdy      <= 1'b0;
            r_vld      <= 1'b0;
            r_last     <= 1'b0;
            r_dout     <= '0;
            r_jet_cnt  <= '0;
            r_drop_cnt <= '0;
            r_ev_num   <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    r_rdy <= 1'b1;
                    if (w_jet_xfer) begin
                        if (r_jet_cnt != '1) r_jet_cnt <= r_jet_cnt + 1'b1;
                        // A full bottom slot means some jet falls off, inserted or not.
                        if (w_slot_vld[NSLOT-1] && (r_drop_cnt != '1))
                            r_drop_cnt <= r_drop_cnt + 1'b1;
                    end
                    if (w_mark_xfer) begin
                        r_rdy   <= 1'b0;
                        r_state <= ST_FLUSH;
                        r_idx   <= '0;
                        r_dout  <= w_emit[0];
                        r_vld   <= 1'b1;
                        r_last  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (w_out_xfer) begin
                        if (r_idx == IW'(NSLOT-1)) begin
                            r_state <= ST_TRAILER;
                            r_dout  <= w_trailer;
                            r_last  <= 1'b1;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_dout <= w_emit[w_next_idx];
                        end
                    end
                end
                ST_TRAILER: begin
                    if (w_out_xfer) begin
                        r_state    <= ST_COLLECT;
                        r_rdy      <= 1'b1;
                        r_vld      <= 1'b0;
                        r_last     <= 1'b0;
                        r_dout     <= '0;
                        r_jet_cnt  <= '0;
                        r_drop_cnt <= '0;
                        r_ev_num   <= r_ev_num + 1'b1;
                    end
                end
                default: r_state <= ST_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_jet_topn_sorter.sv
// tb/tb_jet_topn_sorter.sv - scoreboard bench for jet_topn_sorter with a selection-sort event model
module tb_jet_topn_sorter;
    localparam int NS = 4;

    typedef struct {
        logic [31:0] w;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    jet_topn_sorter_if #(.DW(32)) bus ();

    jet_topn_sorter #(.NSLOT(NS)) dut (
        .s_clk   (clk),
        .reset_n (rst_n),
        .bus     (bus.slave)
    );

    exp_t        exp_q[$];
    logic [31:0] ev_jets[$];
    int          model_ev = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          bp_mode = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected, expected normal progress", name);
    endfunction

    // Reference: pick the NSLOT largest pT jets, earliest arrival winning ties.
    function automatic void model_event();
        logic [31:0] rem[$];
        int          n;
        int          jc;
        int          dc;
        exp_t        e;
        rem = ev_jets;
        n   = ev_jets.size();
        for (int r = 0; r < NS; r++) begin
            if (rem.size() == 0) begin
                e.w = 32'h0;
            end else begin
                int bi = 0;
                for (int i = 1; i < rem.size(); i++)
                    if (rem[i][31:20] > rem[bi][31:20]) bi = i;
                e.w = rem[bi];
                rem.delete(bi);
            end
            e.last = 1'b0;
            exp_q.push_back(e);
        end
        jc = (n > 255) ? 255 : n;
        dc = (n > NS) ? n - NS : 0;
        if (dc > 255) dc = 255;
        e.w    = {4'h0, 12'(model_ev), 8'(jc), 8'(dc)};
        e.last = 1'b1;
        exp_q.push_back(e);
        model_ev = (model_ev + 1) % 4096;
        ev_jets.delete();
    endfunction

    // rdy_in pattern: 0 = always ready, 1 = 1010..., 2 = random
    initial begin
        bus.rdy_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       bus.rdy_in = 1'b1;
                1:       bus.rdy_in = ~bus.rdy_in;
                default: bus.rdy_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        logic        held_v;
        logic [31:0] held_d;
        logic        held_l;
        exp_t        e;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("hold_dout", bus.dout, held_d);
                    check("hold_last", 32'(bus.last_out), 32'(held_l));
                end
                if (bus.vld_out && bus.rdy_in) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_dout", bus.dout, e.w);
                        check("beat_last", 32'(bus.last_out), 32'(e.last));
                    end
                end
                held_v = bus.vld_out && !bus.rdy_in;
                held_d = bus.dout;
                held_l = bus.last_out;
            end
        end
    end

    task automatic send(input logic [31:0] w);
        int t = 0;
        bus.jet_in = w;
        bus.vld_in = 1'b1;
        @(negedge clk);
        while (!bus.rdy_out && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (t >= 200) fail_now("send_timeout");
        @(posedge clk);
        #1;
        bus.vld_in = 1'b0;
        if (w == 32'h0) model_event();
        else ev_jets.push_back(w);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 2000) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        ev_jets.delete();
        model_ev = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_release", 32'(bus.rdy_out), 32'h1);
    endtask

    function automatic logic [31:0] mkjet(input int pt, input int phi);
        return {12'(pt), 5'd0, 5'(phi), 5'd1, 5'd0};
    endfunction

    initial begin
        int cnt;
        int t;
        bus.jet_in = '0;
        bus.vld_in = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_vld_out", 32'(bus.vld_out), 32'h0);
        check("rst_dout", bus.dout, 32'h0);
        check("rst_last", 32'(bus.last_out), 32'h0);
        check("rst_rdy_out", 32'(bus.rdy_out), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_first_edge", 32'(bus.rdy_out), 32'h1);

        send(mkjet(12'h100, 1));
        send(mkjet(12'h300, 2));
        send(mkjet(12'h200, 3));
        send(32'h0);
        drain();

        for (int p = 1; p <= 6; p++) send(mkjet(p, p));
        send(32'h0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rdy_out) break;
            cnt++;
        end
        check("rdy_low_cycles", 32'(cnt), 32'(NS + 1));
        drain();

        send(mkjet(12'h050, 1));
        send(mkjet(12'h050, 2));
        send(32'h0);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 6; i++) send(mkjet($urandom_range(0, 4095), i));
        send(32'h0);
        drain();

        bp_mode = 2;
        for (int ev = 0; ev < 25; ev++) begin
            int nj = $urandom_range(0, 10);
            for (int j = 0; j < nj; j++) begin
                logic [31:0] w = $urandom;
                if (ev % 2 == 0) w[31:20] = 12'($urandom_range(0, 3));
                if (w == 32'h0) w = 32'h1;
                send(w);
            end
            send(32'h0);
        end
        drain();

        bp_mode = 0;
        send(32'h0);
        send(32'h0);
        drain();

        send(mkjet(12'h123, 1));
        send(mkjet(12'h456, 2));
        send(mkjet(12'h789, 3));
        send(32'h0);
        t = 0;
        while (exp_q.size() > NS && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) fail_now("wait_beat2_timeout");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_vld_out", 32'(bus.vld_out), 32'h0);
        check("midrst_dout", bus.dout, 32'h0);
        check("midrst_last", 32'(bus.last_out), 32'h0);
        check("midrst_rdy_out", 32'(bus.rdy_out), 32'h0);
        exp_q.delete();
        ev_jets.delete();
        model_ev = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_rdy_release", 32'(bus.rdy_out), 32'h1);
        send(mkjet(12'h0AA, 4));
        send(mkjet(12'h0BB, 5));
        send(32'h0);
        drain();

        do_reset();
        for (int i = 0; i < 4097; i++) send(32'h0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/jet_topn_sorter.md
Name: jet_topn_sorter

Overview:
- Sits directly downstream of jet_finding_top2 and consumes its 32-bit jet stream (dout/vld_out/rdy_in).
- Per event, keeps the NSLOT highest-pT jets in a register-based insertion sorter.
- At end of event, emits those jets in descending pT, then one trailer word carrying the event number and counts.
- Applies backpressure to the jet finder while flushing.

Parameters:
- NSLOT, 4, number of jets kept and emitted per event (1..8)
- DW, 32, jet word width
- PT_MSB, 31, pT field MSB in jet word
- PT_LSB, 20, pT field LSB (pT = 12 bits unsigned)
- EVW, 12, event counter width

Ports:
- s_clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- jet_in  in  DW  jet word from jet_finding_top2 dout
- vld_in  in  1  jet_in valid
- rdy_out  out  1  block can accept jet_in (drives jet_finding_top2 rdy_in)
- dout  out  DW  sorted jet word or trailer
- vld_out  out  1  dout valid
- rdy_in  in  1  downstream ready
- last_out  out  1  dout is the trailer word

Behaviour:
- Input transfer occurs when vld_in & rdy_out. Output transfer occurs when vld_out & rdy_in.
- jet_in == 0 with vld_in is the end-of-event marker; any nonzero word is a jet, including pT = 0.
- Reset (asynchronous, reset_n low):
  - All slots are invalid and zero; state = COLLECT.
  - Counters are zero.
  - dout = 0, vld_out = 0, last_out = 0.
  - rdy_out = 0 while reset_n is low; rdy_out = 1 from the first s_clk edge after release.
  - Reset asserted mid-flush aborts the event with no partial output afterwards.
- Slots: slot[0..NSLOT-1], each holding a valid bit and a jet word. Slot 0 holds the highest pT.
- COLLECT state (rdy_out = 1):
  - On a jet transfer, compare its pT in parallel against all slots.
  - The jet is inserted at the first position k where slot[k] is invalid or jet pT > slot[k] pT (strictly greater).
  - Slots k..NSLOT-2 shift down by one and slot[NSLOT-1] is discarded.
  - Ties: the earlier jet keeps the higher rank.
  - If no position qualifies, the jet is dropped.
  - Insertion completes in one cycle, so one jet per cycle is accepted back-to-back.
  - jet_cnt (8 bits) increments on every jet and saturates at 255.
  - drop_cnt (8 bits) increments when a jet is discarded, either from slot[NSLOT-1] or rejected outright, and saturates at 255.
  - On a marker transfer, go to FLUSH with idx = 0. rdy_out = 0 from the next cycle.
- FLUSH state (rdy_out = 0):
  - dout = valid ? slot[idx] : 0; vld_out = 1; last_out = 0.
  - The first beat is presented the cycle after the marker is accepted (latency 1).
  - idx advances only on an output transfer; dout and vld_out hold while rdy_in = 0.
  - After the transfer of idx = NSLOT-1, go to TRAILER.
  - Empty slots are emitted as zero words, so exactly NSLOT jet beats go out per event.
- TRAILER state:
  - dout = {4'h0, ev_num[EVW-1:0], jet_cnt, drop_cnt}; vld_out = 1; last_out = 1.
  - On transfer:
    - Clear all slots, jet_cnt and drop_cnt.
    - ev_num increments and wraps at 2^EVW.
    - Return to COLLECT; rdy_out = 1 next cycle.
- Output beats and registers:
  - No bubbles between beats when rdy_in stays high: NSLOT+1 consecutive beats.
  - dout, vld_out and last_out are registered; nothing combinational goes from rdy_in to vld_out.
- Boundary conditions:
  - A marker with zero jets produces NSLOT zero beats plus a trailer with jet_cnt = 0.
  - vld_in asserted while rdy_out = 0 is ignored; the upstream block must hold its data.
  - Back-to-back markers give two complete flushes; the second reports jet_cnt = 0.

Decomposition:
- Shared package jet_pkg holds:
  - jet word field localparams (PT_MSB/PT_LSB, eta [19:15], phi [14:10], ntrk [9:5]);
  - the end-of-event marker constant;
  - trailer field offsets;
  - the state encoding (COLLECT, FLUSH, TRAILER).
- One natural sub-module, jet_sort_slot: a single slot holding its register and comparator.
  - Inputs: candidate, its upper neighbour, and insert/shift controls.
  - Output: the "candidate beats me" flag.
  - Instantiated NSLOT times in a generate loop; the top level derives the insert position from the flags.

Test Plan:
- Reset then jets pT 0x100, 0x300, 0x200, marker, rdy_in = 1 -> beats 0x300, 0x200, 0x100, 0, then trailer ev = 0, jet_cnt = 3, drop_cnt = 0, last_out = 1 on beat 5 only.
- Six jets pT 1..6 back-to-back then marker -> beats 6, 5, 4, 3; trailer jet_cnt = 6, drop_cnt = 2; rdy_out low for exactly 5 cycles when rdy_in = 1.
- Tie: jets A (pT 0x50, phi 1) then B (pT 0x50, phi 2) -> A emitted before B.
- Backpressure: toggle rdy_in 1010... during flush -> each beat held stable until accepted, no beat lost or duplicated, order preserved.
- Marker only, repeated 4097 times -> each trailer jet_cnt = 0; ev_num sequences 0..4095 then wraps to 0.
- reset_n pulled low during beat 2 of a flush -> outputs zero immediately; after release rdy_out = 1, and the next event reports ev = 0 with only its own jets.
